// File: rtl/libv_base_pkg.sv
// Shared libv base definitions: divider FSM states and signed saturation limits.
package libv_base_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } sdiv_state_e;

    // Largest positive value of a signed wo-bit number, held in 33 bits.
    function automatic logic signed [32:0] sat_max(input int unsigned wo);
        return (33'sd1 <<< (wo - 1)) - 33'sd1;
    endfunction

    // Most negative value of a signed wo-bit number, held in 33 bits.
    function automatic logic signed [32:0] sat_min(input int unsigned wo);
        return -(33'sd1 <<< (wo - 1));
    endfunction

endpackage

// File: rtl/libv_base_ssat.sv
// Signed saturation of a WI-bit value into WO bits, flagging when clamping occurred.
module libv_base_ssat
    import libv_base_pkg::*;
#(
    parameter int unsigned WI = 9,
    parameter int unsigned WO = 8
) (
    input  logic signed [WI-1:0] d_i,
    output logic        [WO-1:0] y_o,
    output logic                 ovf_o
);

    localparam logic signed [32:0] MAXV = sat_max(WO);
    localparam logic signed [32:0] MINV = sat_min(WO);

    logic signed [32:0] dx;

    always_comb begin
        dx    = 33'(d_i);
        y_o   = dx[WO-1:0];
        ovf_o = 1'b0;
        if (dx > MAXV) begin
            y_o   = MAXV[WO-1:0];
            ovf_o = 1'b1;
        end else if (dx < MINV) begin
            y_o   = MINV[WO-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/libv_base_sdiv.sv
// Multi-cycle signed divider: restoring division on magnitudes, then sign fix-up
// with quotient saturation and divide-by-zero handling.
module libv_base_sdiv
    import libv_base_pkg::*;
#(
    parameter int unsigned WIA = 8,
    parameter int unsigned WIB = 8,
    parameter int unsigned WO  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [WIA-1:0] a,
    input  logic [WIB-1:0] b,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [WO-1:0]  q,
    output logic [WIB-1:0] r,
    output logic           ovf,
    output logic           dz
);

    localparam int unsigned W  = WIA + 1;
    localparam int unsigned CW = $clog2(WIA + 1);
    localparam logic signed [32:0] QMAX = sat_max(WO);
    localparam logic signed [32:0] QMIN = sat_min(WO);

    sdiv_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   amag_q, amag_d;
    logic [W-1:0]   bmag_q, bmag_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           sa_q, sa_d, sb_q, sb_d;
    logic [WO-1:0]  q_q, q_d;
    logic [WIB-1:0] r_q, r_d;
    logic           ovf_q, ovf_d, dz_q, dz_d;

    logic [W-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic [W-1:0]   trial, diff, qmag, qsgn, rsgn;
    logic           ge;
    logic [WO-1:0]  sat_y;
    logic           sat_ovf;
    logic           unused;

    assign a_ext = {a[WIA-1], a};
    assign b_ext = W'($signed(b));
    assign a_mag = a[WIA-1] ? -a_ext : a_ext;
    assign b_mag = b[WIB-1] ? -b_ext : b_ext;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign trial = {rem_q[W-2:0], amag_q[WIA-1]};
    assign diff  = trial - bmag_q;
    assign ge    = (trial >= bmag_q);

    assign qmag = {1'b0, amag_q[WIA-1:0]};
    assign qsgn = (sa_q ^ sb_q) ? -qmag : qmag;
    assign rsgn = sa_q ? -rem_q : rem_q;

    assign unused = ^{diff[W-1], amag_q[WIA], rsgn[W-1:WIB]};

    libv_base_ssat #(
        .WI(W),
        .WO(WO)
    ) u_ssat (
        .d_i  (qsgn),
        .y_o  (sat_y),
        .ovf_o(sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        amag_d  = amag_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        in_rdy  = (state_q == ST_IDLE);
        out_vld = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (in_vld) begin
                    amag_d  = a_mag;
                    bmag_d  = b_mag;
                    rem_d   = '0;
                    sa_d    = a[WIA-1];
                    sb_d    = b[WIB-1];
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d  = ge ? diff : trial;
                amag_d = {1'b0, amag_q[WIA-2:0], ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIA - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (bmag_q == '0) begin
                    q_d   = sa_q ? QMIN[WO-1:0] : QMAX[WO-1:0];
                    r_d   = '0;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else begin
                    q_d   = sat_y;
                    r_d   = rsgn[WIB-1:0];
                    ovf_d = sat_ovf;
                    dz_d  = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            amag_q  <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amag_q  <= amag_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign q   = q_q;
    assign r   = r_q;
    assign ovf = ovf_q;
    assign dz  = dz_q;

endmodule

// File: tb/tb_libv_base_sdiv.sv
// Scoreboarded bench for libv_base_sdiv: an 8/8/8 and an 8/8/4 instance share stimulus.
module tb_libv_base_sdiv;

    logic       clk = 1'b0;
    logic       rst, ena, in_vld, out_rdy;
    logic [7:0] a, b;

    logic       in_rdy8, out_vld8, ovf8, dz8;
    logic [7:0] q8, r8;
    logic       in_rdy4, out_vld4, ovf4, dz4;
    logic [3:0] q4;
    logic [7:0] r4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dz;
    } exp_t;

    exp_t sb8[$];
    exp_t sb4[$];

    always #5 clk = ~clk;

    libv_base_sdiv #(.WIA(8), .WIB(8), .WO(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .in_vld(in_vld), .in_rdy(in_rdy8),
        .a(a), .b(b), .out_vld(out_vld8), .out_rdy(out_rdy),
        .q(q8), .r(r8), .ovf(ovf8), .dz(dz8)
    );

    libv_base_sdiv #(.WIA(8), .WIB(8), .WO(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .in_vld(in_vld), .in_rdy(in_rdy4),
        .a(a), .b(b), .out_vld(out_vld4), .out_rdy(out_rdy),
        .q(q4), .r(r4), .ovf(ovf4), .dz(dz4)
    );

    // Reference: native truncating division, then clamp to the WO range.
    function automatic exp_t model(input int av, input int bv, input int wo);
        exp_t e;
        int qt, mx, mn;
        mx    = (1 << (wo - 1)) - 1;
        mn    = -(1 << (wo - 1));
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (bv == 0) begin
            e.dz = 1'b1;
            e.r  = 8'd0;
            qt   = (av >= 0) ? mx : mn;
        end else begin
            qt  = av / bv;
            e.r = 8'(av % bv);
            if (qt > mx) begin
                qt = mx; e.ovf = 1'b1;
            end else if (qt < mn) begin
                qt = mn; e.ovf = 1'b1;
            end
        end
        e.q = 8'(qt);
        return e;
    endfunction

    // Latency counts edges from the accepting edge (inclusive) to the one raising out_vld.
    task automatic run_op(input int av, input int bv, input int exp_lat,
                          input int gap_at, input int hold, input string name);
        int   edges;
        exp_t e8, e4;
        edges = 0;
        while (!(in_rdy8 && in_rdy4) && edges < 50) begin
            @(posedge clk); @(negedge clk); edges++;
        end
        checks++;
        if (!(in_rdy8 && in_rdy4)) begin
            errors++;
            $display("FAIL %s in_rdy got %b/%b expected 1/1", name, in_rdy8, in_rdy4);
        end
        a       = av[7:0];
        b       = bv[7:0];
        in_vld  = 1'b1;
        out_rdy = (hold == 0);
        sb8.push_back(model(av, bv, 8));
        sb4.push_back(model(av, bv, 4));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_vld = 1'b0;
        a      = 8'($urandom);
        b      = 8'($urandom);
        while (!out_vld8 && edges < 100) begin
            ena = !(gap_at > 0 && edges >= gap_at && edges < gap_at + 3);
            @(posedge clk); edges++; @(negedge clk);
        end
        ena = 1'b1;
        checks++;
        if (edges != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", name, edges, exp_lat);
        end
        e8 = sb8.pop_front();
        e4 = sb4.pop_front();
        checks++;
        if ({q8, r8, ovf8, dz8} !== {e8.q, e8.r, e8.ovf, e8.dz}) begin
            errors++;
            $display("FAIL %s wo8 got q=%0d r=%0d ovf=%b dz=%b expected q=%0d r=%0d ovf=%b dz=%b",
                     name, $signed(q8), $signed(r8), ovf8, dz8,
                     $signed(e8.q), $signed(e8.r), e8.ovf, e8.dz);
        end
        checks++;
        if ({out_vld4, q4, r4, ovf4, dz4} !== {1'b1, e4.q[3:0], e4.r, e4.ovf, e4.dz}) begin
            errors++;
            $display("FAIL %s wo4 got vld=%b q=%0d r=%0d ovf=%b dz=%b expected vld=1 q=%0d r=%0d ovf=%b dz=%b",
                     name, out_vld4, $signed(q4), $signed(r4), ovf4, dz4,
                     $signed(e4.q[3:0]), $signed(e4.r), e4.ovf, e4.dz);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({out_vld8, in_rdy8, q8, r8, ovf8, dz8} !== {1'b1, 1'b0, e8.q, e8.r, e8.ovf, e8.dz}) begin
                errors++;
                $display("FAIL %s hold%0d got vld=%b rdy=%b q=%0d r=%0d expected vld=1 rdy=0 q=%0d r=%0d",
                         name, i, out_vld8, in_rdy8, $signed(q8), $signed(r8),
                         $signed(e8.q), $signed(e8.r));
            end
        end
        out_rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({out_vld8, in_rdy8} !== 2'b01) begin
            errors++;
            $display("FAIL %s handshake got vld=%b rdy=%b expected vld=0 rdy=1", name, out_vld8, in_rdy8);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_vld8, in_rdy8, q8, r8, ovf8, dz8} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got vld=%b rdy=%b q=%0d r=%0d ovf=%b dz=%b expected 0 1 0 0 0 0",
                     out_vld8, in_rdy8, q8, r8, ovf8, dz8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy8 !== 1'b1 || out_vld8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b vld=%b expected rdy=1 vld=0", in_rdy8, out_vld8);
        end
    endtask

    task automatic test_basic();
        run_op(100, 7, 10, 0, 0, "basic_100_7");
    endtask

    task automatic test_signed();
        run_op(-100, 7, 10, 0, 0, "neg_a");
        run_op(100, -7, 10, 0, 0, "neg_b");
        run_op(-128, -1, 10, 0, 0, "min_by_m1");
        run_op(-128, 1, 10, 0, 0, "min_by_1");
        run_op(127, -128, 10, 0, 0, "max_by_min");
        for (int i = 0; i < 8; i++) begin
            run_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   10, 0, 0, "random");
        end
    endtask

    task automatic test_div_zero();
        run_op(5, 0, 10, 0, 0, "dz_pos");
        run_op(-5, 0, 10, 0, 0, "dz_neg");
        run_op(0, 0, 10, 0, 0, "dz_zero");
    endtask

    task automatic test_narrow_out();
        run_op(7, 2, 10, 0, 0, "wo4_fit");
        run_op(-100, 7, 10, 0, 0, "wo4_neg_sat");
        run_op(100, 7, 10, 0, 0, "wo4_pos_sat");
    endtask

    task automatic test_backpressure();
        run_op(-100, 7, 10, 0, 5, "backpressure");
    endtask

    task automatic test_ena_gap();
        run_op(77, -5, 13, 4, 0, "ena_gap");
    endtask

    task automatic test_back_to_back();
        run_op(-37, 6, 10, 0, 0, "b2b_0");
        run_op(90, 9, 10, 0, 0, "b2b_1");
    endtask

    task automatic test_reset_mid_calc();
        a      = 8'd100;
        b      = 8'd7;
        in_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_vld8, q8, r8, ovf8, dz8, out_vld4, q4, r4} !== '0) begin
            errors++;
            $display("FAIL reset_mid_calc got vld=%b q=%0d r=%0d ovf=%b dz=%b q4=%0d expected all 0",
                     out_vld8, q8, r8, ovf8, dz8, q4);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy8 !== 1'b1 || in_rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release got rdy=%b/%b expected 1/1", in_rdy8, in_rdy4);
        end
        run_op(-1, 1, 10, 0, 0, "after_reset");
    endtask

    initial begin
        rst     = 1'b0;
        ena     = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        a       = 8'd0;
        b       = 8'd0;
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_narrow_out();
        test_backpressure();
        test_ena_gap();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/libv_base_sdiv.md
LIBV_BASE_SDIV -- requirements
Module: libv_base_sdiv

Interface
REQ-001 Parameter WIA, default 8: dividend width, signed two's complement; legal range 2..32.
REQ-002 Parameter WIB, default 8: divisor width, signed; legal range 2..WIA.
REQ-003 Parameter WO, default 8: quotient output width, signed; legal range 2..WIA.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ena  input  1  clock enable; when low, every register holds its value.
REQ-007 in_vld  input  1  dividend/divisor present.
REQ-008 in_rdy  output  1  block can accept an operation.
REQ-009 a  input  WIA  dividend.
REQ-010 b  input  WIB  divisor.
REQ-011 out_vld  output  1  result valid.
REQ-012 out_rdy  input  1  downstream accepts the result.
REQ-013 q  output  WO  quotient, saturated.
REQ-014 r  output  WIB  remainder.
REQ-015 ovf  output  1  quotient saturated because the true quotient exceeds the WO range.
REQ-016 dz  output  1  divisor was zero.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, FIX and DONE; reset state is IDLE.
REQ-018 in_rdy SHALL equal (state==IDLE); an input is accepted on an edge with in_vld & in_rdy & ena.
REQ-019 On accept, the block SHALL latch |a|, |b| and the signs of a and b, clear the iteration counter, and enter CALC.
REQ-020 CALC SHALL perform exactly WIA restoring-division iterations on the magnitudes, one per enabled edge, then enter FIX.
REQ-021 FIX SHALL apply signs, saturation and flags in one enabled edge, then enter DONE.
REQ-022 out_vld SHALL be high only in DONE; with ena held high, it SHALL rise WIA+2 edges after the accepting edge.
REQ-023 In DONE, q, r, ovf and dz SHALL hold stable until the handshake edge (out_vld & out_rdy & ena), which returns the FSM to IDLE.
REQ-024 in_rdy SHALL remain low in DONE, so there is no same-edge accept; throughput is one operation per WIA+3 cycles.
REQ-025 The quotient SHALL truncate toward zero; the remainder SHALL take the dividend's sign, with |r| < |b| and a = q*b + r when neither ovf nor dz is set.
REQ-026 If the signed quotient is above 2^(WO-1)-1, q SHALL be 2^(WO-1)-1; if it is below -2^(WO-1), q SHALL be -2^(WO-1); ovf=1 in either case; r SHALL still be exact.
REQ-027 Overflow covers a=-2^(WIA-1) with b=-1, which saturates to +max.
REQ-028 If b==0: dz=1, ovf=0, r=0, and q SHALL be +max when a>=0, otherwise -max-1 (the most negative value).
REQ-029 Magnitude logic SHALL be WIA+1 bits wide so that |-2^(WIA-1)| is represented without loss.
REQ-030 Input changes outside the accepting edge SHALL have no effect on a running operation.

Reset
REQ-031 Asserting rst SHALL, asynchronously and in any state (including mid-CALC), force: state=IDLE; out_vld=0; q=0; r=0; ovf=0; dz=0; all internal registers=0.
REQ-032 in_rdy SHALL read 1 after rst deasserts; the first accept is possible on the first enabled edge after deassertion.

Structure
REQ-033 State encodings and the saturation-limit constants (+max and -max-1 as a function of WO) SHALL live in the shared libv base package/header.
REQ-034 Saturation SHALL be implemented in one sub-module, libv_base_ssat, which takes a WIA+1-bit signed input and produces a WO-bit output plus an ovf flag; it is reusable by other libv arithmetic blocks.
REQ-035 There SHALL be no multiplier or divider operators; the datapath is shift/subtract only.

Verification
REQ-036 WIA=WIB=WO=8, ena=1, out_rdy=1: a=100, b=7 -> q=14, r=2, ovf=0, dz=0; out_vld rises 10 edges after accept.
REQ-037 Signed cases at 8/8/8: a=-100, b=7 -> q=-14, r=-2; a=100, b=-7 -> q=-14, r=2; a=-128, b=-1 -> q=127, r=0, ovf=1.
REQ-038 Divide by zero at 8/8/8: a=5, b=0 -> q=127, dz=1, r=0; a=-5, b=0 -> q=-128, dz=1.
REQ-039 WO=4: a=100, b=7 -> q=7, ovf=1, r=2; a=-100, b=7 -> q=-8, ovf=1, r=-2.
REQ-040 Backpressure and ena: hold out_rdy=0 for 5 cycles in DONE -> outputs stable and in_rdy=0; toggle ena low for 3 cycles mid-CALC -> latency grows by exactly 3 and the result is unchanged.
REQ-041 Reset: assert rst at the 4th CALC cycle -> all outputs read 0 immediately and in_rdy=1 after release; the next operation (a=-1, b=1 -> q=-1, r=0) completes correctly.
